// File: rtl/fir_filter_pkg.sv
// Shared types and constants for the multi-channel FIR filter.
// Holds the FSM state enum, mode encodings and accumulator sizing helpers.
package fir_filter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MAC  = 2'd1,
      ST_OUT  = 2'd2
   } state_t;

   localparam logic MODE_AVG = 1'b0;
   localparam logic MODE_FIR = 1'b1;

   // Headroom bit so the rounding add cannot wrap the accumulator.
   localparam int RND_GUARD_W = 1;

   // Full-precision accumulator width: product bits plus tap growth.
   function automatic int acc_width(input int dw, input int cw,
                                    input int taps);
      return dw + cw + $clog2(taps);
   endfunction

endpackage

// File: rtl/fir_mac.sv
// Signed multiply-accumulate with synchronous clear and enable.
// clr alone zeroes acc; clr with en loads a*b; en alone adds a*b.
module fir_mac
   import fir_filter_pkg::*;
#(
   parameter int A_W   = 24,
   parameter int B_W   = 16,
   parameter int ACC_W = 43
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clr,
   input  logic                    en,
   input  logic signed [A_W-1:0]   a,
   input  logic signed [B_W-1:0]   b,
   output logic signed [ACC_W-1:0] acc
);

   logic signed [A_W+B_W-1:0] prod;
   logic signed [ACC_W-1:0]   prod_x;
   logic signed [ACC_W-1:0]   base;
   logic signed [ACC_W-1:0]   acc_d;
   logic signed [ACC_W-1:0]   acc_q;

   always_comb begin
      prod   = a * b;
      prod_x = ACC_W'(prod);
      base   = clr ? '0 : acc_q;
      acc_d  = acc_q;
      if (en) begin
         acc_d = base + prod_x;
      end else if (clr) begin
         acc_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc = acc_q;

endmodule

// File: rtl/fir_filter_mc.sv
// Multi-channel time-multiplexed FIR / moving-average filter, one MAC.
// Ports: CLOCK_50/reset, in_* and out_* valid/ready streams, mode, coef_*, flush, busy.
module fir_filter_mc
   import fir_filter_pkg::*;
#(
   parameter int DATA_W   = 24,
   parameter int COEF_W   = 16,
   parameter int TAPS     = 8,
   parameter int CHANNELS = 2
) (
   input  logic                         CLOCK_50,
   input  logic                         reset,
   input  logic [CHANNELS*DATA_W-1:0]   in_data,
   input  logic                         in_valid,
   output logic                         in_ready,
   output logic [CHANNELS*DATA_W-1:0]   out_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   input  logic                         mode,
   input  logic                         coef_we,
   input  logic [$clog2(TAPS)-1:0]      coef_addr,
   input  logic signed [COEF_W-1:0]     coef_wdata,
   input  logic                         flush,
   output logic                         busy
);

   localparam int LOG2T = $clog2(TAPS);
   localparam int N     = TAPS * CHANNELS;
   localparam int CNT_W = $clog2(N + 1);
   localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int ACC_W = acc_width(DATA_W, COEF_W, TAPS);
   localparam int EXT_W = ACC_W + RND_GUARD_W;

   localparam logic signed [EXT_W-1:0] RND =
      EXT_W'(longint'(1) <<< (COEF_W - 2));
   localparam logic signed [EXT_W-1:0] SAT_HI =
      EXT_W'((longint'(1) <<< (DATA_W - 1)) - 1);
   localparam logic signed [EXT_W-1:0] SAT_LO =
      EXT_W'(-(longint'(1) <<< (DATA_W - 1)));
   localparam logic signed [COEF_W-1:0] COEF_ONE_Q =
      COEF_W'((longint'(1) <<< (COEF_W - 1)) - 1);
   localparam logic signed [COEF_W-1:0] COEF_UNIT = COEF_W'(1);

   state_t                     state_q, state_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic                       mode_q, mode_d;
   logic signed [DATA_W-1:0]   dl_q [CHANNELS][TAPS];
   logic signed [DATA_W-1:0]   dl_d [CHANNELS][TAPS];
   logic signed [COEF_W-1:0]   coef_q [TAPS];
   logic signed [COEF_W-1:0]   coef_d [TAPS];
   logic signed [ACC_W-1:0]    sum_q [CHANNELS];
   logic signed [ACC_W-1:0]    sum_d [CHANNELS];
   logic [CHANNELS*DATA_W-1:0] out_q, out_d;
   logic                       out_valid_q, out_valid_d;

   logic                       accept;
   logic                       mac_run;
   logic                       mac_done;
   logic                       mac_en;
   logic                       mac_clr;
   logic [LOG2T-1:0]           tap_idx;
   logic [CH_W-1:0]            ch_idx;
   logic [CH_W-1:0]            prev_ch;
   logic signed [DATA_W-1:0]   mac_a;
   logic signed [COEF_W-1:0]   mac_b;
   logic signed [ACC_W-1:0]    acc;
   logic [CHANNELS*DATA_W-1:0] shaped;

   // Round/saturate for FIR mode, floor-average for boxcar mode.
   function automatic logic signed [DATA_W-1:0] shape(
      input logic signed [ACC_W-1:0] a,
      input logic                    m
   );
      logic signed [EXT_W-1:0] t;
      logic signed [EXT_W-1:0] s;
      logic signed [ACC_W-1:0] avg;
      t   = EXT_W'(a) + RND;
      s   = t >>> (COEF_W - 1);
      avg = a >>> LOG2T;
      if (m == MODE_AVG) begin
         shape = DATA_W'(avg);
      end else if (s > SAT_HI) begin
         shape = DATA_W'(SAT_HI);
      end else if (s < SAT_LO) begin
         shape = DATA_W'(SAT_LO);
      end else begin
         shape = DATA_W'(s);
      end
   endfunction

   assign accept    = in_valid && (state_q == ST_IDLE);
   assign in_ready  = (state_q == ST_IDLE);
   assign busy      = (state_q != ST_IDLE);
   assign out_data  = out_q;
   assign out_valid = out_valid_q;

   // cnt walks channel-major: high bits pick channel, low bits pick tap.
   // cnt == N is the drain cycle where the last channel's sum settles.
   always_comb begin
      tap_idx  = cnt_q[LOG2T-1:0];
      ch_idx   = cnt_q[LOG2T +: CH_W];
      prev_ch  = ch_idx - 1'b1;
      mac_run  = (state_q == ST_MAC) && (cnt_q != CNT_W'(N));
      mac_done = (state_q == ST_MAC) && (cnt_q == CNT_W'(N));
      mac_en   = mac_run;
      mac_clr  = accept || (mac_run && (tap_idx == '0));
      mac_a    = dl_q[ch_idx][tap_idx];
      mac_b    = (mode_q == MODE_FIR) ? coef_q[tap_idx] : COEF_UNIT;
   end

   fir_mac #(
      .A_W   (DATA_W),
      .B_W   (COEF_W),
      .ACC_W (ACC_W)
   ) u_mac (
      .clk   (CLOCK_50),
      .rst_n (reset),
      .clr   (mac_clr),
      .en    (mac_en),
      .a     (mac_a),
      .b     (mac_b),
      .acc   (acc)
   );

   // The last channel's sum is still in the accumulator at drain time.
   always_comb begin
      shaped = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         if (c == CHANNELS - 1) begin
            shaped[c*DATA_W +: DATA_W] = shape(acc, mode_q);
         end else begin
            shaped[c*DATA_W +: DATA_W] = shape(sum_q[c], mode_q);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      mode_d      = mode_q;
      out_d       = out_q;
      out_valid_d = out_valid_q;
      dl_d        = dl_q;
      coef_d      = coef_q;
      sum_d       = sum_q;
      unique case (state_q)
         ST_IDLE: begin
            if (coef_we) begin
               coef_d[coef_addr] = coef_wdata;
            end
            if (flush) begin
               for (int c = 0; c < CHANNELS; c++) begin
                  for (int t = 0; t < TAPS; t++) begin
                     dl_d[c][t] = '0;
                  end
               end
            end
            if (accept) begin
               for (int c = 0; c < CHANNELS; c++) begin
                  for (int t = TAPS - 1; t > 0; t--) begin
                     dl_d[c][t] = flush ? '0 : dl_q[c][t-1];
                  end
                  dl_d[c][0] = in_data[c*DATA_W +: DATA_W];
               end
               mode_d  = mode;
               cnt_d   = '0;
               state_d = ST_MAC;
            end
         end
         ST_MAC: begin
            // A channel boundary means acc holds the previous channel's sum.
            if ((cnt_q != '0) && (tap_idx == '0)) begin
               sum_d[prev_ch] = acc;
            end
            if (mac_done) begin
               out_d       = shaped;
               out_valid_d = 1'b1;
               state_d     = ST_OUT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_OUT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         mode_q      <= MODE_AVG;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         for (int c = 0; c < CHANNELS; c++) begin
            sum_q[c] <= '0;
            for (int t = 0; t < TAPS; t++) begin
               dl_q[c][t] <= '0;
            end
         end
         for (int t = 0; t < TAPS; t++) begin
            coef_q[t] <= (t == 0) ? COEF_ONE_Q : '0;
         end
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         mode_q      <= mode_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         sum_q       <= sum_d;
         dl_q        <= dl_d;
         coef_q      <= coef_d;
      end
   end

endmodule

// File: tb/tb_fir_filter_mc.sv
// Self-checking bench for fir_filter_mc with a behavioural filter model.
// Directed vectors plus a per-cycle output compare against the model.
module tb_fir_filter_mc;

   logic        CLOCK_50;
   logic        reset;
   logic [47:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [47:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        mode;
   logic        coef_we;
   logic [2:0]  coef_addr;
   logic signed [15:0] coef_wdata;
   logic        flush;
   logic        busy;

   fir_filter_mc dut (
      .CLOCK_50   (CLOCK_50),
      .reset      (reset),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .mode       (mode),
      .coef_we    (coef_we),
      .coef_addr  (coef_addr),
      .coef_wdata (coef_wdata),
      .flush      (flush),
      .busy       (busy)
   );

   initial CLOCK_50 = 1'b0;
   always #5 CLOCK_50 = ~CLOCK_50;

   int          n_chk  = 0;
   int          n_fail = 0;
   int          dlm [2][8];
   int          coefm [8];
   logic [47:0] exp_data = '0;
   longint      g0, g1;

   task automatic check(input string name, input longint got,
                        input longint want);
      n_chk++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d", name, got, want);
      end
   endtask

   // Whenever a result is presented it must match the model.
   always @(negedge CLOCK_50) begin
      if (reset && out_valid) begin
         n_chk++;
         if (out_data !== exp_data) begin
            n_fail++;
            $display("FAIL out_data: got %h, want %h", out_data, exp_data);
         end
      end
   end

   function automatic logic [47:0] model_eval(input bit m);
      logic [47:0] r;
      longint      acc;
      longint      v;
      r = '0;
      for (int c = 0; c < 2; c++) begin
         acc = 0;
         for (int t = 0; t < 8; t++) begin
            acc += longint'(dlm[c][t]) * (m ? longint'(coefm[t]) : 64'sd1);
         end
         if (m) begin
            v = (acc + 16384) >>> 15;
            if (v > 8388607) v = 8388607;
            if (v < -8388608) v = -8388608;
         end else begin
            v = acc >>> 3;
         end
         r[c*24 +: 24] = v[23:0];
      end
      return r;
   endfunction

   function automatic longint out_ch(input int c);
      logic [23:0] s;
      s = out_data[c*24 +: 24];
      return longint'($signed(s));
   endfunction

   task automatic do_reset();
      @(negedge CLOCK_50);
      reset = 1'b0;
      in_valid = 1'b0;
      coef_we = 1'b0;
      flush = 1'b0;
      #1;
      check("rst_out_valid", longint'(out_valid), 0);
      check("rst_out_data", longint'(out_data), 0);
      check("rst_busy", longint'(busy), 0);
      repeat (2) @(negedge CLOCK_50);
      reset = 1'b1;
      #1;
      check("rst_in_ready", longint'(in_ready), 1);
      for (int c = 0; c < 2; c++)
         for (int t = 0; t < 8; t++) dlm[c][t] = 0;
      for (int t = 0; t < 8; t++) coefm[t] = 0;
      coefm[0] = 32767;
   endtask

   task automatic coef_write(input int a, input int v);
      @(negedge CLOCK_50);
      coef_we = 1'b1;
      coef_addr = 3'(a);
      coef_wdata = 16'(v);
      @(posedge CLOCK_50);
      coefm[a] = v;
      #1;
      coef_we = 1'b0;
   endtask

   // wr_mode: 0 none, 1 coef[0] write at the accept edge, 2 write in MAC.
   task automatic sample(input int d0, input int d1, input bit m,
                         input bit fl, input bit bp, input int wr_mode,
                         input int wr_val, output longint o0,
                         output longint o1);
      int n;
      bit rdy_bad;
      logic [47:0] held;
      @(negedge CLOCK_50);
      n = 0;
      while (!in_ready && n < 40) begin
         @(negedge CLOCK_50);
         n++;
      end
      check("idle_before_accept", longint'(in_ready), 1);
      in_data = {d1[23:0], d0[23:0]};
      in_valid = 1'b1;
      mode = m;
      flush = fl;
      out_ready = !bp;
      if (wr_mode == 1) begin
         coef_we = 1'b1;
         coef_addr = 3'd0;
         coef_wdata = 16'(wr_val);
      end
      @(posedge CLOCK_50);
      if (wr_mode == 1) coefm[0] = wr_val;
      for (int c = 0; c < 2; c++) begin
         for (int t = 7; t > 0; t--) dlm[c][t] = fl ? 0 : dlm[c][t-1];
      end
      dlm[0][0] = d0;
      dlm[1][0] = d1;
      exp_data = model_eval(m);
      #1;
      in_valid = 1'b0;
      flush = 1'b0;
      coef_we = 1'b0;
      mode = !m;
      n = 0;
      rdy_bad = 1'b0;
      do begin
         @(posedge CLOCK_50);
         n++;
         #1;
         if (in_ready) rdy_bad = 1'b1;
         if (wr_mode == 2 && n == 3) begin
            coef_we = 1'b1;
            coef_addr = 3'd0;
            coef_wdata = 16'(wr_val);
         end
         if (n == 4) coef_we = 1'b0;
      end while (!out_valid && n < 40);
      check("latency", n, 17);
      check("in_ready_low_busy", longint'(rdy_bad), 0);
      o0 = out_ch(0);
      o1 = out_ch(1);
      held = out_data;
      if (bp) begin
         for (int i = 0; i < 5; i++) begin
            @(negedge CLOCK_50);
            in_valid = 1'b1;
            in_data = {24'h123456, 24'h654321};
            @(posedge CLOCK_50);
            #1;
            check("bp_in_ready", longint'(in_ready), 0);
            check("bp_stable", longint'(out_data == held), 1);
         end
         @(negedge CLOCK_50);
         in_valid = 1'b0;
         out_ready = 1'b1;
      end
      @(posedge CLOCK_50);
      #1;
      check("out_valid_drop", longint'(out_valid), 0);
   endtask

   initial begin
      reset = 1'b1;
      in_data = '0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      mode = 1'b0;
      coef_we = 1'b0;
      coef_addr = '0;
      coef_wdata = '0;
      flush = 1'b0;
      do_reset();

      // Passthrough with reset coefficients
      sample(8, -16, 1'b1, 1'b0, 1'b0, 0, 0, g0, g1);
      check("pass_ch0", g0, 8);
      check("pass_ch1", g1, -16);

      // Boxcar average
      do_reset();
      begin
         int seq [8] = '{8, 16, 8, 32, 8, 16, 8, 8};
         for (int i = 0; i < 8; i++) begin
            sample(seq[i], -8, 1'b0, 1'b0, 1'b0, 0, 0, g0, g1);
            if (i == 0) check("avg_first", g0, 1);
         end
      end
      check("avg_eighth_ch0", g0, 13);
      check("avg_eighth_ch1", g1, -8);

      // Flush with accept
      sample(24, -24, 1'b0, 1'b1, 1'b0, 0, 0, g0, g1);
      check("flush_ch0", g0, 3);
      check("flush_ch1", g1, -3);

      // Coef write on the accept edge takes effect for that sample
      sample(40, -40, 1'b1, 1'b0, 1'b0, 1, 16384, g0, g1);
      check("wr_accept_ch0", g0, 20);
      check("wr_accept_ch1", g1, -20);

      // Backpressure, then confirm delay lines unchanged
      sample(100, -100, 1'b1, 1'b0, 1'b1, 0, 0, g0, g1);
      check("bp_ch0", g0, 50);
      check("bp_ch1", g1, -50);
      sample(7, 7, 1'b0, 1'b0, 1'b0, 0, 0, g0, g1);
      check("after_bp_ch0", g0, 21);
      check("after_bp_ch1", g1, -20);

      // Saturation
      do_reset();
      for (int t = 0; t < 8; t++) coef_write(t, 32767);
      for (int i = 0; i < 8; i++)
         sample(8388607, -8388608, 1'b1, 1'b0, 1'b0, 0, 0, g0, g1);
      check("sat_pos_ch0", g0, 8388607);
      check("sat_neg_ch1", g1, -8388608);
      for (int i = 0; i < 8; i++)
         sample(-8388608, 8388607, 1'b1, 1'b0, 1'b0, 0, 0, g0, g1);
      check("sat_neg_ch0", g0, -8388608);
      check("sat_pos_ch1", g1, 8388607);

      // Coef write during MAC ignored, in IDLE honoured
      do_reset();
      sample(50, 60, 1'b1, 1'b0, 1'b0, 2, 0, g0, g1);
      check("mac_wr_ign_ch0", g0, 50);
      check("mac_wr_ign_ch1", g1, 60);
      coef_write(0, 0);
      sample(50, 60, 1'b1, 1'b0, 1'b0, 0, 0, g0, g1);
      check("idle_wr_ch0", g0, 0);
      check("idle_wr_ch1", g1, 0);

      // Reset mid-MAC aborts
      do_reset();
      @(negedge CLOCK_50);
      in_data = {24'd5, 24'd77};
      in_valid = 1'b1;
      mode = 1'b1;
      @(posedge CLOCK_50);
      #1;
      in_valid = 1'b0;
      repeat (5) @(posedge CLOCK_50);
      #1;
      check("mid_mac_busy", longint'(busy), 1);
      do_reset();
      sample(100, -7, 1'b1, 1'b0, 1'b0, 0, 0, g0, g1);
      check("post_abort_ch0", g0, 100);
      check("post_abort_ch1", g1, -7);

      repeat (3) @(negedge CLOCK_50);
      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
